restoring_div_seq: RTL and testbench

RESTORING_DIV_SEQ -- requirements
Module: restoring_div_seq

---
 rtl/restoring_div_seq_if.sv | 29 ++
 rtl/restoring_div_seq.sv | 130 +++++++++++++
 tb/tb_restoring_div_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/restoring_div_seq_if.sv
// Request/result bundle for the sequential restoring divider.
// The master issues divisions; the slave (divider) reports status and results.
`timescale 1ns/1ps

interface restoring_div_seq_if;
  // start is sampled only while the divider is idle (busy=0, done=0).
  // dividend/divisor are captured on that same edge. busy covers the
  // iteration cycles. done is a one-cycle pulse, and the results are valid
  // from that pulse until the next accepted start.
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/restoring_div_seq.sv
// Sequential 8-bit / 4-bit unsigned restoring divider.
// Each RUN cycle produces one quotient bit, MSB first.
`timescale 1ns/1ps

module restoring_div_seq (
  input  logic                    clk,
  input  logic                    rst,
  restoring_div_seq_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] prem_q, prem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] qwork_q, qwork_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [4:0] r5;
  logic [4:0] r5_sub;
  logic       ge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 5'd0;
      cnt_q   <= 3'd0;
      qwork_q <= 7'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      qwork_q <= qwork_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.divisor == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring step. A set prem_q[4] would mean the shifted value already
  // exceeds any 4-bit divisor; it stays clear because prem < divisor.
  always_comb begin
    r5     = {prem_q[3:0], dvd_q[cnt_q]};
    ge     = prem_q[4] | (r5 >= {1'b0, dvs_q});
    r5_sub = r5 - {1'b0, dvs_q};
  end

  always_comb begin
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    qwork_d = qwork_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          prem_d  = 5'd0;
          cnt_d   = 3'd7;
          qwork_d = 7'd0;
          dbz_d   = (bus.divisor == 4'd0);
          if (bus.divisor == 4'd0) begin
            quot_d = 8'hFF;
            rem_d  = 4'h0;
          end
        end
      end
      S_RUN: begin
        prem_d  = ge ? r5_sub : r5;
        qwork_d = {qwork_q[5:0], ge};
        cnt_d   = cnt_q - 3'd1;
        // Results are published only at the last step so they stay stable
        // for the whole operation.
        if (cnt_q == 3'd0) begin
          quot_d = {qwork_q, ge};
          rem_d  = ge ? r5_sub[3:0] : r5[3:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == S_RUN);
    bus.done        = (state_q == S_DONE);
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
    bus.dbg_state   = state_q;
  end

endmodule

// File: tb/tb_restoring_div_seq.sv
// Directed and exhaustive bench for restoring_div_seq; expected results are
// hand-computed for directed vectors and modelled with / and % otherwise.
`timescale 1ns/1ps

module tb_restoring_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  restoring_div_seq_if bus ();

  restoring_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks    = 0;
  int n_errors    = 0;
  int overlap_cnt = 0;
  logic [12:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && bus.busy && bus.done) overlap_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is aligned 1ns after an edge with the divider idle.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez);
    int lat;
    int busy_cnt;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, (b == 4'd0) ? 1 : 9);
    check_eq({tag, "_busy_cycles"}, busy_cnt, (b == 4'd0) ? 0 : 8);
    check_eq({tag, "_quotient"}, bus.quotient, eq);
    check_eq({tag, "_remainder"}, bus.remainder, er);
    check_eq({tag, "_div_by_zero"}, bus.div_by_zero, ez);
    tick();
    check_eq({tag, "_done_one_cycle"}, bus.done, 0);
    check_eq({tag, "_quotient_held"}, bus.quotient, eq);
  endtask

  initial begin
    int lat;
    int done_cnt;
    int done_at;
    logic [12:0] e;
    logic [7:0] mq;
    logic [3:0] mr;

    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    rst          = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_quotient", bus.quotient, 0);
    check_eq("rst_remainder", bus.remainder, 0);
    check_eq("rst_div_by_zero", bus.div_by_zero, 0);
    check_eq("rst_state", bus.dbg_state, 0);
    rst = 1'b0;
    tick();

    run_div("basic_200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    run_div("ext_255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    run_div("ext_255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    run_div("ext_5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    run_div("ext_0_3", 8'd0, 4'd3, 8'd0, 4'd0, 1'b0);
    run_div("dbz_100_0", 8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
    run_div("after_dbz_12_5", 8'd12, 4'd5, 8'd2, 4'd2, 1'b0);

    // A start pulse during RUN must be ignored.
    bus.start    = 1'b1;
    bus.dividend = 8'd60;
    bus.divisor  = 4'd4;
    tick();
    bus.start = 1'b0;
    done_cnt  = 0;
    done_at   = 0;
    for (int i = 2; i <= 16; i++) begin
      if (i == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 4'd3;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        done_cnt++;
        done_at = i;
      end
    end
    bus.start = 1'b0;
    check_eq("busy_start_done_count", done_cnt, 1);
    check_eq("busy_start_done_edge", done_at, 9);
    check_eq("busy_start_quotient", bus.quotient, 15);
    check_eq("busy_start_remainder", bus.remainder, 0);

    // Reset in the middle of a run aborts it with no done pulse.
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_state", bus.dbg_state, 0);
    check_eq("midrst_quotient", bus.quotient, 0);
    check_eq("midrst_remainder", bus.remainder, 0);
    check_eq("midrst_div_by_zero", bus.div_by_zero, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    check_eq("midrst_no_done", done_cnt, 0);
    run_div("post_rst_17_4", 8'd17, 4'd4, 8'd4, 4'd1, 1'b0);

    // Every operand pair with start held high, back to back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.dividend = a[7:0];
        bus.divisor  = b[3:0];
        bus.start    = 1'b1;
        if (b == 0) begin
          mq = 8'hFF;
          mr = 4'd0;
        end else begin
          mq = 8'(a / b);
          mr = 4'(a % b);
        end
        exp_q.push_back({mq, mr, (b == 0)});
        if (a != 0 || b != 0) tick();
        tick();
        lat = 1;
        while (!bus.done && lat < 20) begin
          tick();
          lat++;
        end
        e = exp_q.pop_front();
        check_eq("exh_latency", lat, (b == 0) ? 1 : 9);
        check_eq("exh_result", {bus.quotient, bus.remainder, bus.div_by_zero}, e);
      end
    end
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("busy_done_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
